// File: rtl/prio10_arbiter.sv
// prio10_arbiter: grants one shared resource to one of 10 requesters.
// Default build uses fixed priority, where the highest set index wins.
// Defining PRIO10_ROUND_ROBIN_EN switches to rotating priority, based on
// the last owner.
// A grant is non-preemptive. It is held until done, until the owner
// withdraws its request, or until TIMEOUT cycles have elapsed. Each grant
// is followed by one dead cycle (RELEASE).
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   req      request lines; req[k] is held by requester k until served
//   done     current owner finished; only looked at while granted
//   gnt      one-hot grant (registered), zero when idle
//   gnt_code index of granted requester 0..9 (registered), 4'd15 when idle
//   busy     high while a grant is active (registered)
//   timeout  one-cycle pulse when a grant was revoked by the timeout
module prio10_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] req,
  input  logic       done,
  output logic [9:0] gnt,
  output logic [3:0] gnt_code,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       NO_CODE  = 4'd15;

  state_t           state;
  logic [3:0]       owner;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       pick;
  logic             owner_quit;

`ifdef PRIO10_ROUND_ROBIN_EN
  logic [3:0]  last;
  logic        found;
  int unsigned rr_idx;

  // Scan downward from last-1, wrap 0 -> 9, and end at last itself.
  always_comb begin
    pick   = last;
    found  = 1'b0;
    rr_idx = 0;
    for (int d = 1; d <= 10; d++) begin
      rr_idx = (32'(last) + 32'd10 - 32'(d)) % 32'd10;
      if (!found && req[rr_idx]) begin
        pick  = 4'(rr_idx);
        found = 1'b1;
      end
    end
  end
`else
  // Fixed priority: ascending scan, so the highest set index is kept.
  always_comb begin
    pick = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (req[i]) pick = 4'(i);
    end
  end
`endif

  // The owner ends the grant itself; such an exit never counts as a timeout.
  assign owner_quit = done || !req[owner];

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 4'd0;
      cnt      <= '0;
      gnt      <= '0;
      gnt_code <= NO_CODE;
      busy     <= 1'b0;
      timeout  <= 1'b0;
`ifdef PRIO10_ROUND_ROBIN_EN
      last     <= 4'd9;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            owner    <= pick;
            cnt      <= '0;
            gnt      <= 10'(1) << pick;
            gnt_code <= pick;
            busy     <= 1'b1;
`ifdef PRIO10_ROUND_ROBIN_EN
            last     <= pick;
`endif
          end
        end
        GRANT: begin
          if (owner_quit || cnt == CNT_LAST) begin
            state    <= RELEASE;
            gnt      <= '0;
            gnt_code <= NO_CODE;
            busy     <= 1'b0;
            timeout  <= !owner_quit;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio10_arbiter.sv
// Self-checking bench for prio10_arbiter. The bench has four parts:
// vector table, timeout sequence, reset sequence and randomized traffic.
// A behavioural reference model is compared against the DUT every cycle.
// The reference model tracks phase/owner/held-cycle count.
module tb_prio10_arbiter;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] req;
  logic       done;
  logic [9:0] gnt;
  logic [3:0] gnt_code;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state: phase 0=idle 1=granted 2=dead cycle.
  int m_phase, m_own, m_held, m_last;
  bit m_to;

  typedef struct {
    logic [9:0] req;
    logic       done;
    logic [9:0] gnt;
    logic [3:0] code;
    logic       busy;
    logic       to;
  } vec_t;
  vec_t vt[20];

  prio10_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_code(gnt_code), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(logic [9:0] r);
`ifdef PRIO10_ROUND_ROBIN_EN
    for (int d = 1; d <= 10; d++) begin
      int k;
      k = (m_last + 10 - d) % 10;
      if (r[k]) return k;
    end
    return m_last;
`else
    for (int k = 9; k >= 0; k--) if (r[k]) return k;
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_own = 0; m_held = 0; m_last = 9; m_to = 0;
  endtask

  task automatic model_step(logic [9:0] r, logic d);
    bit fin;
    m_to = 0;
    case (m_phase)
      0: if (r != 0) begin
        m_own = model_pick(r); m_last = m_own; m_phase = 1; m_held = 1;
      end
      1: begin
        fin = d || !r[m_own];
        if (fin || m_held == TIMEOUT) begin
          m_phase = 2; m_to = !fin;
        end else m_held++;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [9:0] eg;
    eg = (m_phase == 1) ? (10'(1) << m_own) : 10'd0;
    check("model_gnt", 32'(gnt), 32'(eg));
    check("model_code", 32'(gnt_code), (m_phase == 1) ? 32'(m_own) : 32'd15);
    check("model_busy", 32'(busy), 32'(m_phase == 1));
    check("model_timeout", 32'(timeout), 32'(m_to));
  endtask

  // One clock: model consumes the inputs present at the edge; compare 1 unit later.
  task automatic tick();
    @(posedge clk);
    model_step(req, done);
    #1;
    check_model();
  endtask

  task automatic check_idle(string name);
    check({name, "_gnt"}, 32'(gnt), 32'd0);
    check({name, "_code"}, 32'(gnt_code), 32'd15);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_to"}, 32'(timeout), 32'd0);
  endtask

  initial begin
    int len;
    int seq[11];
    vt[0]  = '{10'h300, 1'b0, 10'h200, 4'd9,  1'b1, 1'b0};
    vt[1]  = '{10'h300, 1'b1, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[2]  = '{10'h000, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[3]  = '{10'h001, 1'b0, 10'h001, 4'd0,  1'b1, 1'b0};
    vt[4]  = '{10'h001, 1'b0, 10'h001, 4'd0,  1'b1, 1'b0};
    vt[5]  = '{10'h000, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[6]  = '{10'h000, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[7]  = '{10'h008, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[8]  = '{10'h008, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[9]  = '{10'h008, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[10] = '{10'h008, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[11] = '{10'h008, 1'b1, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[12] = '{10'h008, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[13] = '{10'h008, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[14] = '{10'h108, 1'b0, 10'h008, 4'd3,  1'b1, 1'b0};
    vt[15] = '{10'h100, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[16] = '{10'h100, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[17] = '{10'h100, 1'b0, 10'h100, 4'd8,  1'b1, 1'b0};
    vt[18] = '{10'h000, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    vt[19] = '{10'h000, 1'b0, 10'h000, 4'd15, 1'b0, 1'b0};
    seq = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};

    // Power-on reset.
    rst = 1'b1; req = '0; done = 1'b0;
    model_reset();
    #3;
    check_idle("por");
    @(negedge clk) rst = 1'b0;

`ifndef PRIO10_ROUND_ROBIN_EN
    // Vector table: priority pick, withdraw, done in 4th cycle, non-preemption.
    for (int i = 0; i < 20; i++) begin
      req = vt[i].req; done = vt[i].done;
      tick();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vt[i].gnt));
      check($sformatf("vec%0d_code", i), 32'(gnt_code), 32'(vt[i].code));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vt[i].busy));
      check($sformatf("vec%0d_to", i), 32'(timeout), 32'(vt[i].to));
    end
`endif

    // Timeout: requester 5 holds without done.
    req = 10'h020; done = 1'b0;
    tick();
    len = 0;
    for (int c = 0; c < 40 && gnt == 10'h020; c++) begin
      len++;
      tick();
    end
    check("to_len", 32'(len), 32'(TIMEOUT));
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_rel_gnt", 32'(gnt), 32'd0);
    tick();
    check("to_pulse_end", 32'(timeout), 32'd0);
    check("to_idle_gnt", 32'(gnt), 32'd0);
    tick();
    check("to_regrant", 32'(gnt), 32'h020);
    check("to_regrant_code", 32'(gnt_code), 32'd5);

    // Asynchronous reset in the middle of a grant, with all requests high.
    req = 10'h3FF;
    tick();
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_idle("rst_async");
    model_reset();
    req = '0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst_after");
    end

`ifdef PRIO10_ROUND_ROBIN_EN
    // Round-robin rotation with done on every grant.
    req = 10'h3FF; done = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      check($sformatf("rr%0d_code", i), 32'(gnt_code), 32'(seq[i]));
      done = 1'b1;
      tick();
      done = 1'b0;
      tick();
    end
    req = '0;
    tick();
    tick();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 10; k++)
        if ($urandom_range(0, 15) == 0) req[k] = ~req[k];
      done = ($urandom_range(0, 11) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prio10_arbiter.md
Name: prio10_arbiter

Overview:
- Arbitrates one shared resource among 10 requesters, using the CD40147 decimal-priority scheme: highest index wins.
- Registers the winner and holds its grant until the owner finishes or a timeout expires.
- Presents the grant as one-hot and as a 4-bit decimal code, so downstream logic sees the same code format as the combinational 10-to-4 encoder.
- Sits between request sources (buttons, UART/LED tasks) and the shared peripheral they contend for.

Parameters:
- TIMEOUT, 16, maximum number of cycles a single grant may be held; legal range 2..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  10  request lines; req[k] is held high by requester k until it is served.
- done  input  1  the current owner has finished; sampled only in state GRANT.
- gnt  output  10  one-hot grant; all zero when no grant is active.
- gnt_code  output  4  index of the granted requester, 0..9; 4'd15 when no grant is active.
- busy  output  1  high while in state GRANT.
- timeout  output  1  one-cycle pulse when a grant is revoked by the timeout.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, gnt=0, gnt_code=15, busy=0, timeout=0, counter=0.
- All outputs are registered; there is no combinational path from any input to any output.
- State IDLE:
  - If req is nonzero, latch winner w = highest set index of req.
  - Next cycle: state=GRANT, gnt[w]=1, gnt_code=w, busy=1, counter=0.
  - Latency from req rising (while idle) to gnt: exactly 1 clock edge.
  - If req is zero, stay in IDLE.
- State GRANT (owner w):
  - counter increments by 1 each cycle; it saturates and does not wrap.
  - Exit on the next edge to RELEASE if any of these hold:
    - done=1
    - req[w]=0 (owner withdrew)
    - counter == TIMEOUT-1
  - Exit priority for flagging: done or withdrawal wins over timeout. If done and the timeout condition hold on the same cycle, timeout is not pulsed.
  - Timeout-only exit: timeout=1 for exactly one cycle, coincident with the first RELEASE cycle.
  - A new higher-priority request during GRANT does not preempt the owner; the grant is non-preemptive.
- State RELEASE:
  - gnt=0, gnt_code=15, busy=0 for exactly one cycle.
  - Always returns to IDLE next cycle.
  - This guarantees a one-cycle dead time between successive owners.
- Back-to-back service:
  - A requester still requesting after release is re-evaluated in IDLE.
  - A timed-out requester that keeps req high can win again; under fixed priority, starvation of lower indices is permitted.
- Minimum grant length is 1 cycle. Maximum is TIMEOUT cycles.
- req bits are assumed synchronous to clk; no synchronizers are included.
- Reset asserted mid-GRANT drops gnt immediately (asynchronous), with no timeout pulse.

Optional Feature:
- Macro: PRIO10_ROUND_ROBIN_EN.
- Defined:
  - Round-robin selection. A 4-bit last-owner register (reset value 9) rotates priority.
  - In IDLE, the winner is the first set req index scanning downward from last-1, wrapping from 0 to 9, ending at last itself.
  - last is updated to w on entry to GRANT.
- Not defined:
  - Pure fixed priority, highest index wins, as described above.
  - No last-owner register is synthesized.

Test Plan:
- Reset and idle: assert rst mid-run with req=10'h3FF -> gnt=0, gnt_code=15, busy=0 immediately, asynchronously; after release with req=0, outputs remain idle.
- Priority pick: req=10'b1100000000 from IDLE -> next edge gnt=10'b1000000000, gnt_code=9; req=10'b0000000001 alone -> gnt_code=0.
- Done handshake: grant to 3, pulse done in the 4th GRANT cycle -> one RELEASE cycle with gnt=0 and code=15, then IDLE; timeout stays 0.
- Timeout: TIMEOUT=16, req[5] held, done=0 -> gnt[5] high for exactly 16 cycles, then a timeout pulse of 1 cycle, then regrant to 5 two cycles after revoke.
- Withdrawal and non-preemption: owner 2 granted, raise req[8] -> gnt remains on 2; drop req[2] -> release, then grant to 8.
- Round robin (PRIO10_ROUND_ROBIN_EN): req=10'h3FF with done pulsed on each grant -> gnt_code sequence 8,7,6,...,0,9,8.
